pwm_multi_ramp: RTL and testbench

Multi-channel, parametrised PWM generator with soft-start/slew ramping, the successor to the single-channel 0–10 speed PWM stage that drives the line follower's motor drivers. Each channel takes a speed target in 0..SPEED_MAX and produces a glitch-free PWM waveform on a shared period counter. Duty changes take effect only at period boundaries and ramp one step at a time toward the target, limiting motor inrush and step torque. It sits between the steering/control FSM, which writes targets, and the H-bridge enable pins.

---
 rtl/pwm_multi_ramp.sv | 127 ++++++++++++
 tb/tb_pwm_multi_ramp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM generator sharing one period counter, with per-channel
// soft-start ramping toward a saturated speed target at period boundaries.
module pwm_multi_ramp #(
  parameter int CHANNELS  = 2,
  parameter int PERIOD    = 100000,
  parameter int SPEED_W   = 4,
  parameter int SPEED_MAX = 10,
  parameter int RAMP_DIV  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic [CHANNELS*SPEED_W-1:0] speed_in,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic                        period_tick,
  output logic [CHANNELS-1:0]         ramping
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int CMP_W  = $clog2(PERIOD + 1);
  localparam int PROD_W = CMP_W + SPEED_W;
  localparam int RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [SPEED_W-1:0] LVL_MAX   = SPEED_W'(SPEED_MAX);
  localparam logic [RDIV_W-1:0]  RDIV_LAST = (RAMP_DIV > 1) ? RDIV_W'(RAMP_DIV - 1) : '0;
  localparam logic [PROD_W-1:0]  PERIOD_P  = PROD_W'(PERIOD);
  localparam logic [PROD_W-1:0]  SMAX_P    = PROD_W'(SPEED_MAX);

  logic [CNT_W-1:0]   cnt;
  logic [RDIV_W-1:0]  rdiv;
  logic [SPEED_W-1:0] target     [CHANNELS];
  logic [SPEED_W-1:0] level      [CHANNELS];
  logic [SPEED_W-1:0] level_next [CHANNELS];
  logic [CMP_W-1:0]   cmp        [CHANNELS];
  logic [CMP_W-1:0]   cmp_next   [CHANNELS];
  logic [PROD_W-1:0]  prod       [CHANNELS];
  logic [PROD_W-1:0]  quot       [CHANNELS];
  logic               boundary;

  function automatic logic [SPEED_W-1:0] clamp(input logic [SPEED_W-1:0] v);
    return (v > LVL_MAX) ? LVL_MAX : v;
  endfunction

  assign boundary = (cnt == CNT_LAST);

  // Next level: jump straight to target, or take a single step toward it once
  // every RAMP_DIV boundaries; the compare threshold follows from that level.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      level_next[i] = level[i];
      if (RAMP_DIV == 0) begin
        level_next[i] = target[i];
      end else if (rdiv == RDIV_LAST) begin
        if (level[i] < target[i]) begin
          level_next[i] = level[i] + SPEED_W'(1);
        end else if (level[i] > target[i]) begin
          level_next[i] = level[i] - SPEED_W'(1);
        end
      end
      prod[i]     = PROD_W'(level_next[i]) * PERIOD_P;
      quot[i]     = prod[i] / SMAX_P;
      cmp_next[i] = CMP_W'(quot[i]);
    end
  end

  always_comb begin
    ramping = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ramping[i] = (level[i] != target[i]);
    end
  end

  // Targets survive en low so that re-enabling soft-starts toward them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= clamp(speed_in[i*SPEED_W +: SPEED_W]);
      end
    end
  end

  // cmp only moves on a boundary, so each period's waveform is fixed at its
  // start; cnt < PERIOD keeps a full-scale threshold high across the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rdiv        <= '0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        level[i] <= '0;
        cmp[i]   <= '0;
      end
    end else if (!en) begin
      cnt         <= '0;
      rdiv        <= '0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        level[i] <= '0;
        cmp[i]   <= '0;
      end
    end else begin
      cnt         <= boundary ? '0 : cnt + CNT_W'(1);
      period_tick <= boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (CMP_W'(cnt) < cmp[i]);
      end
      if (boundary) begin
        for (int i = 0; i < CHANNELS; i++) begin
          level[i] <= level_next[i];
          cmp[i]   <= cmp_next[i];
        end
        if (RAMP_DIV > 1) begin
          rdiv <= (rdiv == RDIV_LAST) ? '0 : rdiv + RDIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Scoreboard bench: three instances (jump, slow ramp, unit ramp); a monitor per
// instance measures each full period and checks it against queued expectations.
module tb_pwm_multi_ramp;

  typedef struct {
    int inst;
    int hi0;
    int hi1;
    int len;
    int ramp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_v    [3];
  logic       load_v  [3];
  logic [7:0] speed_v [3];
  exp_t       expq [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int inst, input logic en, input logic ld,
                               input logic [3:0] s0, input logic [3:0] s1);
    en_v[inst]    = en;
    load_v[inst]  = ld;
    speed_v[inst] = {s1, s0};
  endtask

  task automatic pushExp(input int inst, input int hi0, input int hi1, input int ramp);
    exp_t e;
    e.inst = inst;
    e.hi0  = hi0;
    e.hi1  = hi1;
    e.len  = (inst == 1) ? 60 : 20;
    e.ramp = ramp;
    expq.push_back(e);
  endtask

  task automatic checkWindow(input int inst, input int a0, input int a1, input int len,
                             input int ramp);
    exp_t e;
    if (expq.size() == 0) begin
      checkOutput($sformatf("dut%0d unexpected period", inst), inst, -1);
    end else begin
      e = expq.pop_front();
      checkOutput($sformatf("dut%0d instance", inst), inst, e.inst);
      checkOutput($sformatf("dut%0d ch0 high time", inst), a0, e.hi0);
      checkOutput($sformatf("dut%0d ch1 high time", inst), a1, e.hi1);
      checkOutput($sformatf("dut%0d period length", inst), len, e.len);
      checkOutput($sformatf("dut%0d ramping", inst), ramp, e.ramp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [1:0] pwm;
    logic [1:0] ramp;
    logic       tick;

    pwm_multi_ramp #(
      .CHANNELS (2),
      .PERIOD   ((g == 1) ? 60 : 20),
      .SPEED_W  (4),
      .SPEED_MAX(10),
      .RAMP_DIV ((g == 0) ? 0 : ((g == 1) ? 2 : 1))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en_v[g]),
      .load       (load_v[g]),
      .speed_in   (speed_v[g]),
      .pwm_out    (pwm),
      .period_tick(tick),
      .ramping    (ramp)
    );

    // A period's samples run from the cycle after one tick up to and including
    // the next tick, because pwm_out lags the counter by one cycle.
    initial begin
      int acc0;
      int acc1;
      int len;
      bit synced;
      acc0 = 0;
      acc1 = 0;
      len = 0;
      synced = 1'b0;
      forever begin
        @(negedge clk);
        if (rst || !en_v[g]) begin
          acc0 = 0;
          acc1 = 0;
          len = 0;
          synced = 1'b0;
        end else begin
          acc0 += int'(pwm[0]);
          acc1 += int'(pwm[1]);
          len++;
          if (tick) begin
            if (synced) checkWindow(g, acc0, acc1, len, int'(ramp));
            synced = 1'b1;
            acc0 = 0;
            acc1 = 0;
            len = 0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en_v[i] = 1'b0;
      load_v[i] = 1'b0;
      speed_v[i] = '0;
    end
    cycles(3);
    rst = 1'b0;

    // Jump mode: 5/10, saturation, mid-period and coincident loads.
    pushExp(0, 10, 20, 0);
    pushExp(0, 10, 20, 0);
    pushExp(0, 20, 20, 0);
    pushExp(0, 20, 20, 0);
    pushExp(0, 8, 20, 0);
    pushExp(0, 16, 20, 1);
    pushExp(0, 16, 20, 0);
    pushExp(0, 4, 20, 0);
    applyStimulus(0, 1, 1, 5, 10);
    cycles(1);
    applyStimulus(0, 1, 0, 5, 10);
    cycles(44);
    applyStimulus(0, 1, 1, 15, 10);
    cycles(1);
    applyStimulus(0, 1, 0, 15, 10);
    checkOutput("saturating load ramping", int'(g_dut[0].ramp), 1);
    checkOutput("saturated target", int'(g_dut[0].u_dut.target[0]), 10);
    cycles(39);
    applyStimulus(0, 1, 1, 4, 10);
    cycles(1);
    applyStimulus(0, 1, 0, 4, 10);
    cycles(21);
    applyStimulus(0, 1, 1, 8, 10);
    cycles(1);
    applyStimulus(0, 1, 0, 8, 10);
    cycles(31);
    applyStimulus(0, 1, 1, 2, 10);
    cycles(1);
    applyStimulus(0, 1, 0, 2, 10);
    cycles(44);

    // Asynchronous reset mid-period with both outputs high.
    checkOutput("pwm before reset", int'(g_dut[0].pwm), 3);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("pwm during reset", int'(g_dut[0].pwm), 0);
    checkOutput("tick during reset", int'(g_dut[0].tick), 0);
    checkOutput("ramping during reset", int'(g_dut[0].ramp), 0);
    cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      checkOutput("pwm after reset", int'(g_dut[0].pwm), 0);
      checkOutput("tick after reset", int'(g_dut[0].tick), 0);
      checkOutput("ramping after reset", int'(g_dut[0].ramp), 0);
    end
    checkOutput("queue drained dut0", expq.size(), 0);

    // Slow ramp 0->3 then back down to 0, two periods per step.
    pushExp(1, 0, 0, 1);
    pushExp(1, 6, 0, 1);
    pushExp(1, 6, 0, 1);
    pushExp(1, 12, 0, 1);
    pushExp(1, 12, 0, 0);
    pushExp(1, 18, 0, 1);
    pushExp(1, 18, 0, 1);
    pushExp(1, 12, 0, 1);
    pushExp(1, 12, 0, 1);
    pushExp(1, 6, 0, 1);
    pushExp(1, 6, 0, 0);
    pushExp(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 3, 0);
    cycles(1);
    applyStimulus(1, 1, 0, 3, 0);
    cycles(379);
    applyStimulus(1, 1, 1, 0, 0);
    cycles(1);
    applyStimulus(1, 1, 0, 0, 0);
    cycles(401);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("queue drained dut1", expq.size(), 0);

    // Unit ramp to 4, enable drop mid-period, then soft restart.
    pushExp(2, 2, 0, 1);
    pushExp(2, 4, 0, 1);
    pushExp(2, 6, 0, 0);
    applyStimulus(2, 1, 1, 4, 0);
    cycles(1);
    applyStimulus(2, 1, 0, 4, 0);
    cycles(84);
    checkOutput("pwm before enable drop", int'(g_dut[2].pwm), 1);
    applyStimulus(2, 0, 0, 4, 0);
    cycles(1);
    checkOutput("pwm after enable drop", int'(g_dut[2].pwm), 0);
    checkOutput("tick after enable drop", int'(g_dut[2].tick), 0);
    checkOutput("cnt after enable drop", int'(g_dut[2].u_dut.cnt), 0);
    checkOutput("level after enable drop", int'(g_dut[2].u_dut.level[0]), 0);
    checkOutput("ramping after enable drop", int'(g_dut[2].ramp), 1);
    checkOutput("queue drained dut2 first run", expq.size(), 0);
    pushExp(2, 2, 0, 1);
    pushExp(2, 4, 0, 1);
    pushExp(2, 6, 0, 0);
    pushExp(2, 8, 0, 0);
    applyStimulus(2, 1, 0, 4, 0);
    cycles(102);
    applyStimulus(2, 0, 0, 4, 0);
    checkOutput("queue drained dut2 restart", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
